// File: rtl/soc_reset_sequencer_if.sv
// Pin bundle of soc_reset_sequencer: raw board button in, staged resets and busy flag out.
// Status fields (rst_count, rst_cause) exist only when RST_STATUS_EN is defined.
interface soc_reset_sequencer_if;
    logic       btn_n;
    logic       periph_rst_n;
    logic       core_rst_n;
    logic       rst_busy;
`ifdef RST_STATUS_EN
    logic [7:0] rst_count;
    logic       rst_cause;

    modport master (
        input  btn_n,
        output periph_rst_n,
        output core_rst_n,
        output rst_busy,
        output rst_count,
        output rst_cause
    );

    modport slave (
        output btn_n,
        input  periph_rst_n,
        input  core_rst_n,
        input  rst_busy,
        input  rst_count,
        input  rst_cause
    );
`else
    modport master (
        input  btn_n,
        output periph_rst_n,
        output core_rst_n,
        output rst_busy
    );

    modport slave (
        output btn_n,
        input  periph_rst_n,
        input  core_rst_n,
        input  rst_busy
    );
`endif
endinterface

// File: rtl/soc_reset_sequencer.sv
// Staged SoC reset: debounced board button plus system reset hold both domains, then release
// peripherals before the CPU core. Optional RST_STATUS_EN adds a press counter and last-cause flag.
module soc_reset_sequencer #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int HOLD_CYCLES     = 32,
    parameter int STAGGER_CYCLES  = 8,
    parameter int CNT_W           = 16
) (
    input  logic                  clock,
    input  logic                  resetn,
    soc_reset_sequencer_if.master rif
);
    typedef enum logic [1:0] {
        ST_HOLD  = 2'd0,
        ST_REL_P = 2'd1,
        ST_RUN   = 2'd2
    } state_e;

    localparam logic [CNT_W-1:0] DEB_MAX  = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] HOLD_MAX = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] STAG_MAX = CNT_W'(STAGGER_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};

    logic [1:0]       btn_sync_q, btn_sync_d;
    logic [CNT_W-1:0] deb_cnt_q, deb_cnt_d;
    logic             pressed_prev_q, pressed_prev_d;
    logic             press_q, press_d;
    logic             btn_pressed_s;
    state_e           state_q, state_d;
    logic [CNT_W-1:0] timer_q, timer_d;
    logic             periph_rst_n_q, periph_rst_n_d;
    logic             core_rst_n_q, core_rst_n_d;
    logic             rst_busy_q, rst_busy_d;
`ifdef RST_STATUS_EN
    logic [7:0]       rst_count_q, rst_count_d;
    logic             rst_cause_q, rst_cause_d;
`endif

    // Synchroniser, debounce counter and registered press edge.
    // The level needs DEBOUNCE_CYCLES low samples: a saturated counter plus a still-low synced bit.
    always_comb begin
        btn_sync_d    = {btn_sync_q[0], rif.btn_n};
        btn_pressed_s = (deb_cnt_q == DEB_MAX) && !btn_sync_q[1];
        if (btn_sync_q[1]) begin
            deb_cnt_d = CNT_ZERO;
        end else if (deb_cnt_q == DEB_MAX) begin
            deb_cnt_d = deb_cnt_q;
        end else begin
            deb_cnt_d = deb_cnt_q + CNT_ONE;
        end
        pressed_prev_d = btn_pressed_s;
        press_d        = btn_pressed_s && !pressed_prev_q;
    end

    // Sequencer next state and shared timer; a press edge beats any timed exit.
    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        if (press_q) begin
            state_d = ST_HOLD;
            timer_d = CNT_ZERO;
        end else begin
            case (state_q)
                ST_HOLD: begin
                    if (btn_pressed_s) begin
                        timer_d = CNT_ZERO;
                    end else if (timer_q == HOLD_MAX) begin
                        state_d = ST_REL_P;
                        timer_d = CNT_ZERO;
                    end else begin
                        timer_d = timer_q + CNT_ONE;
                    end
                end
                ST_REL_P: begin
                    if (timer_q == STAG_MAX) begin
                        state_d = ST_RUN;
                        timer_d = CNT_ZERO;
                    end else begin
                        timer_d = timer_q + CNT_ONE;
                    end
                end
                ST_RUN: begin
                    timer_d = CNT_ZERO;
                end
                default: begin
                    state_d = ST_HOLD;
                    timer_d = CNT_ZERO;
                end
            endcase
        end
    end

    // Outputs decoded from the next state so they change on the same edge as the state.
    always_comb begin
        periph_rst_n_d = 1'b0;
        core_rst_n_d   = 1'b0;
        rst_busy_d     = 1'b1;
        case (state_d)
            ST_HOLD: begin
                periph_rst_n_d = 1'b0;
                core_rst_n_d   = 1'b0;
                rst_busy_d     = 1'b1;
            end
            ST_REL_P: begin
                periph_rst_n_d = 1'b1;
                core_rst_n_d   = 1'b0;
                rst_busy_d     = 1'b1;
            end
            ST_RUN: begin
                periph_rst_n_d = 1'b1;
                core_rst_n_d   = 1'b1;
                rst_busy_d     = 1'b0;
            end
            default: begin
                periph_rst_n_d = 1'b0;
                core_rst_n_d   = 1'b0;
                rst_busy_d     = 1'b1;
            end
        endcase
    end

`ifdef RST_STATUS_EN
    // Saturating press counter and last-cause flag; only the system reset clears them.
    always_comb begin
        rst_count_d = rst_count_q;
        rst_cause_d = rst_cause_q;
        if (press_q) begin
            rst_cause_d = 1'b1;
            if (rst_count_q != 8'd255) begin
                rst_count_d = rst_count_q + 8'd1;
            end else begin
                rst_count_d = rst_count_q;
            end
        end else begin
            rst_cause_d = rst_cause_q;
        end
    end
`endif

    // State registers with synchronous active-low system reset.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            btn_sync_q     <= 2'b11;
            deb_cnt_q      <= CNT_ZERO;
            pressed_prev_q <= 1'b0;
            press_q        <= 1'b0;
            state_q        <= ST_HOLD;
            timer_q        <= CNT_ZERO;
            periph_rst_n_q <= 1'b0;
            core_rst_n_q   <= 1'b0;
            rst_busy_q     <= 1'b1;
`ifdef RST_STATUS_EN
            rst_count_q    <= 8'd0;
            rst_cause_q    <= 1'b0;
`endif
        end else begin
            btn_sync_q     <= btn_sync_d;
            deb_cnt_q      <= deb_cnt_d;
            pressed_prev_q <= pressed_prev_d;
            press_q        <= press_d;
            state_q        <= state_d;
            timer_q        <= timer_d;
            periph_rst_n_q <= periph_rst_n_d;
            core_rst_n_q   <= core_rst_n_d;
            rst_busy_q     <= rst_busy_d;
`ifdef RST_STATUS_EN
            rst_count_q    <= rst_count_d;
            rst_cause_q    <= rst_cause_d;
`endif
        end
    end

    assign rif.periph_rst_n = periph_rst_n_q;
    assign rif.core_rst_n   = core_rst_n_q;
    assign rif.rst_busy     = rst_busy_q;
`ifdef RST_STATUS_EN
    assign rif.rst_count    = rst_count_q;
    assign rif.rst_cause    = rst_cause_q;
`endif

endmodule

// File: tb/tb_soc_reset_sequencer.sv
// Self-checking bench for soc_reset_sequencer: vector table, corner-case sequences and random
// button/reset traffic against a quiet-time reference model. Status checks under RST_STATUS_EN.
module tb_soc_reset_sequencer;
    localparam int DEB  = 16;
    localparam int HOLD = 32;
    localparam int STAG = 8;

    logic clock = 1'b0;
    logic resetn;

    soc_reset_sequencer_if rif ();

    soc_reset_sequencer #(
        .DEBOUNCE_CYCLES(DEB),
        .HOLD_CYCLES    (HOLD),
        .STAGGER_CYCLES (STAG),
        .CNT_W          (16)
    ) dut (
        .clock (clock),
        .resetn(resetn),
        .rif   (rif)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: quiet = edges since the last reset cause, saturating at HOLD+STAG.
    int m_quiet    = 0;
    int m_lowrun   = 0;
    bit m_lvl      = 1'b0;
    bit m_lvl_prev = 1'b0;
    bit m_pend     = 1'b0;
`ifdef RST_STATUS_EN
    int m_count = 0;
    bit m_cause = 1'b0;
`endif

    typedef struct {
        logic rn;
        logic b;
        int   n;
        logic ep;
        logic ec;
        logic eb;
    } vec_t;

    vec_t tbl [20];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // One clock edge with the given inputs, then model update and per-cycle comparison.
    task automatic step(input logic rn, input logic b);
        bit press_act;
        resetn    = rn;
        rif.btn_n = b;
        @(posedge clock);
        #1;
        if (!rn) begin
            m_quiet    = 0;
            m_lowrun   = 0;
            m_lvl      = 1'b0;
            m_lvl_prev = 1'b0;
            m_pend     = 1'b0;
`ifdef RST_STATUS_EN
            m_count = 0;
            m_cause = 1'b0;
`endif
        end else begin
            press_act = m_pend;
            m_pend    = m_lvl && !m_lvl_prev;
            if (press_act || (m_quiet < HOLD && m_lvl)) begin
                m_quiet = 0;
            end else if (m_quiet < HOLD + STAG) begin
                m_quiet++;
            end
`ifdef RST_STATUS_EN
            if (press_act) begin
                m_cause = 1'b1;
                if (m_count < 255) m_count++;
            end
`endif
            m_lvl_prev = m_lvl;
            m_lvl      = (m_lowrun >= DEB);
            m_lowrun   = b ? 0 : m_lowrun + 1;
        end
        chk("model periph_rst_n", 32'(rif.periph_rst_n), 32'(m_quiet >= HOLD));
        chk("model core_rst_n",   32'(rif.core_rst_n),   32'(m_quiet >= HOLD + STAG));
        chk("model rst_busy",     32'(rif.rst_busy),     32'(m_quiet < HOLD + STAG));
        chk("core before periph", 32'(rif.core_rst_n & ~rif.periph_rst_n), 32'(0));
`ifdef RST_STATUS_EN
        chk("model rst_count", 32'(rif.rst_count), 32'(m_count));
        chk("model rst_cause", 32'(rif.rst_cause), 32'(m_cause));
`endif
    endtask

    initial begin
        logic core_hi;
        resetn    = 1'b0;
        rif.btn_n = 1'b1;

        // rn, btn, cycles, expected periph/core/busy after the last cycle
        tbl[0]  = '{1'b0, 1'b1,  5, 1'b0, 1'b0, 1'b1};
        tbl[1]  = '{1'b1, 1'b1, 31, 1'b0, 1'b0, 1'b1};
        tbl[2]  = '{1'b1, 1'b1,  1, 1'b1, 1'b0, 1'b1};
        tbl[3]  = '{1'b1, 1'b1,  7, 1'b1, 1'b0, 1'b1};
        tbl[4]  = '{1'b1, 1'b1,  1, 1'b1, 1'b1, 1'b0};
        tbl[5]  = '{1'b1, 1'b0, 10, 1'b1, 1'b1, 1'b0};
        tbl[6]  = '{1'b1, 1'b1, 20, 1'b1, 1'b1, 1'b0};
        tbl[7]  = '{1'b1, 1'b0, 18, 1'b1, 1'b1, 1'b0};
        tbl[8]  = '{1'b1, 1'b0,  1, 1'b0, 1'b0, 1'b1};
        tbl[9]  = '{1'b1, 1'b0, 81, 1'b0, 1'b0, 1'b1};
        tbl[10] = '{1'b1, 1'b1, 33, 1'b0, 1'b0, 1'b1};
        tbl[11] = '{1'b1, 1'b1,  1, 1'b1, 1'b0, 1'b1};
        tbl[12] = '{1'b1, 1'b1,  7, 1'b1, 1'b0, 1'b1};
        tbl[13] = '{1'b1, 1'b1,  1, 1'b1, 1'b1, 1'b0};
        tbl[14] = '{1'b1, 1'b0, 15, 1'b1, 1'b1, 1'b0};
        tbl[15] = '{1'b1, 1'b1, 30, 1'b1, 1'b1, 1'b0};
        tbl[16] = '{1'b1, 1'b0, 16, 1'b1, 1'b1, 1'b0};
        tbl[17] = '{1'b1, 1'b1,  2, 1'b1, 1'b1, 1'b0};
        tbl[18] = '{1'b1, 1'b1,  1, 1'b0, 1'b0, 1'b1};
        tbl[19] = '{1'b1, 1'b1, 60, 1'b1, 1'b1, 1'b0};

        for (int i = 0; i < 20; i++) begin
            repeat (tbl[i].n) step(tbl[i].rn, tbl[i].b);
            chk($sformatf("tbl[%0d] periph_rst_n", i), 32'(rif.periph_rst_n), 32'(tbl[i].ep));
            chk($sformatf("tbl[%0d] core_rst_n", i),   32'(rif.core_rst_n),   32'(tbl[i].ec));
            chk($sformatf("tbl[%0d] rst_busy", i),     32'(rif.rst_busy),     32'(tbl[i].eb));
        end

        // Press validated while peripherals are released: core must never come out of reset.
        repeat (3) step(1'b0, 1'b1);
        repeat (16) step(1'b1, 1'b1);
        repeat (15) step(1'b1, 1'b0);
        chk("relp periph before release", 32'(rif.periph_rst_n), 32'(0));
        step(1'b1, 1'b0);
        chk("relp periph released", 32'(rif.periph_rst_n), 32'(1));
        core_hi = rif.core_rst_n;
        repeat (2) step(1'b1, 1'b0);
        chk("relp periph still up", 32'(rif.periph_rst_n), 32'(1));
        step(1'b1, 1'b0);
        chk("relp periph reasserted", 32'(rif.periph_rst_n), 32'(0));
        for (int i = 0; i < 20; i++) begin
            step(1'b1, 1'b0);
            core_hi = core_hi | rif.core_rst_n;
        end
        for (int i = 0; i < 33; i++) begin
            step(1'b1, 1'b1);
            core_hi = core_hi | rif.core_rst_n;
        end
        chk("relp periph full hold", 32'(rif.periph_rst_n), 32'(0));
        chk("relp core never rose", 32'(core_hi), 32'(0));
        step(1'b1, 1'b1);
        chk("relp periph after hold", 32'(rif.periph_rst_n), 32'(1));
        repeat (8) step(1'b1, 1'b1);
        chk("relp core after stagger", 32'(rif.core_rst_n), 32'(1));

        // Button held low across system reset release.
        repeat (4) step(1'b0, 1'b0);
        repeat (50) step(1'b1, 1'b0);
        chk("held periph", 32'(rif.periph_rst_n), 32'(0));
        chk("held busy", 32'(rif.rst_busy), 32'(1));
        repeat (33) step(1'b1, 1'b1);
        chk("held periph edge 33", 32'(rif.periph_rst_n), 32'(0));
        step(1'b1, 1'b1);
        chk("held periph edge 34", 32'(rif.periph_rst_n), 32'(1));

        // Random segments of button level with occasional system resets.
        for (int s = 0; s < 180; s++) begin
            int   len;
            logic b;
            if ($urandom_range(0, 19) == 0) begin
                len = $urandom_range(1, 4);
                repeat (len) step(1'b0, 1'($urandom_range(0, 1)));
            end else begin
                b   = 1'($urandom_range(0, 1));
                len = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 20) : $urandom_range(12, 60);
                repeat (len) step(1'b1, b);
            end
        end

`ifdef RST_STATUS_EN
        // Counter saturation and clearing by the system reset only.
        repeat (2) step(1'b0, 1'b1);
        for (int i = 0; i < 300; i++) begin
            repeat (17) step(1'b1, 1'b0);
            repeat (3) step(1'b1, 1'b1);
        end
        chk("status count saturated", 32'(rif.rst_count), 32'(255));
        chk("status cause button", 32'(rif.rst_cause), 32'(1));
        step(1'b0, 1'b1);
        chk("status count cleared", 32'(rif.rst_count), 32'(0));
        chk("status cause cleared", 32'(rif.rst_cause), 32'(0));
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
